// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types for the FIFO write arbiter: the ownership FSM state encoding.
package fifo_write_arbiter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/fifo_write_arbiter_round_robin_selector.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping N-1 -> 0.
module round_robin_selector #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   always_comb begin
      int unsigned k;
      logic        found;
      k       = 0;
      found   = 1'b0;
      grant_o = '0;
      idx_o   = '0;
      for (int unsigned off = 0; off < N; off++) begin
         k = (32'(ptr_i) + off) % N;
         if (!found && req_i[IW'(k)]) begin
            found            = 1'b1;
            idx_o            = IW'(k);
            grant_o[IW'(k)]  = 1'b1;
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin FIFO write arbiter with per-channel lock-to-own; zero-latency grant path.
// Optional per-channel saturating grant counters under FIFO_WRITE_ARBITER_STATISTICS_EN.
module fifo_write_arbiter
   import fifo_write_arbiter_pkg::*;
#(
   parameter int unsigned REQUESTERS  = 4,
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [REQUESTERS-1:0]            request_enable,
   input  logic [REQUESTERS-1:0][WIDTH-1:0] request_data,
   input  logic [REQUESTERS-1:0]            request_lock,
   output logic [REQUESTERS-1:0]            request_grant,
   output logic                             write_enable,
   output logic [WIDTH-1:0]                 write_data,
   input  logic                             write_full
`ifdef FIFO_WRITE_ARBITER_STATISTICS_EN
  ,output logic [REQUESTERS-1:0][COUNT_WIDTH-1:0] grant_count
`endif
);

   localparam int unsigned IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   if (REQUESTERS < 2 || COUNT_WIDTH < 1) begin : g_bad_params
      $error("fifo_write_arbiter: REQUESTERS must be >= 2 and COUNT_WIDTH >= 1");
   end

   state_e                  state_q, state_d;
   logic [IW-1:0]           ptr_q, ptr_d;
   logic [IW-1:0]           owner_q, owner_d;
   logic [REQUESTERS-1:0]   sel_grant;
   logic [IW-1:0]           sel_idx;
   logic                    sel_valid;

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      return (32'(i) == REQUESTERS - 1) ? '0 : IW'(32'(i) + 1);
   endfunction

   round_robin_selector #(
      .N  (REQUESTERS),
      .IW (IW)
   ) u_sel (
      .req_i   (request_enable),
      .ptr_i   (ptr_q),
      .grant_o (sel_grant),
      .idx_o   (sel_idx),
      .valid_o (sel_valid)
   );

   // Grant decision and next state; reset forces the grant path quiet immediately.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      request_grant = '0;
      if (!reset && !write_full) begin
         case (state_q)
            IDLE: begin
               if (sel_valid) begin
                  request_grant = sel_grant;
                  if (request_lock[sel_idx]) begin
                     state_d = LOCKED;
                     owner_d = sel_idx;
                  end else begin
                     ptr_d = next_idx(sel_idx);
                  end
               end
            end
            LOCKED: begin
               request_grant[owner_q] = request_enable[owner_q];
               // Release needs some request pending so a silent bus keeps state frozen.
               if (!request_lock[owner_q] && (|request_enable)) begin
                  state_d = IDLE;
                  ptr_d   = next_idx(owner_q);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      write_data = '0;
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
         if (request_grant[i]) write_data = write_data | request_data[i];
      end
   end

   assign write_enable = |request_grant;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
      end
   end

`ifdef FIFO_WRITE_ARBITER_STATISTICS_EN
   logic [REQUESTERS-1:0][COUNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (request_grant[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + COUNT_WIDTH'(1);
         end
      end
   end

   assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench: stimulus pushes the hand-computed grant per cycle, a negedge monitor checks it.
module tb_fifo_write_arbiter;

   logic            clock = 1'b0;
   logic            reset;
   logic [3:0]      request_enable;
   logic [3:0][7:0] request_data;
   logic [3:0]      request_lock;
   logic [3:0]      request_grant;
   logic            write_enable;
   logic [7:0]      write_data;
   logic            write_full;
`ifdef FIFO_WRITE_ARBITER_STATISTICS_EN
   logic [3:0][1:0] grant_count;
`endif

   typedef struct {
      logic [3:0] grant;
      logic       chk_cnt;
      logic [1:0] cnt0;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   fifo_write_arbiter #(
      .REQUESTERS  (4),
      .WIDTH       (8),
      .COUNT_WIDTH (2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .request_enable (request_enable),
      .request_data   (request_data),
      .request_lock   (request_lock),
      .request_grant  (request_grant),
      .write_enable   (write_enable),
      .write_data     (write_data),
      .write_full     (write_full)
`ifdef FIFO_WRITE_ARBITER_STATISTICS_EN
     ,.grant_count    (grant_count)
`endif
   );

   task automatic step(input logic rst, input logic [3:0] en, input logic [3:0] lk,
                       input logic full, input logic [3:0] exp_g, input string nm,
                       input logic cc = 1'b0, input logic [1:0] cv = 2'd0);
      exp_t e;
      @(posedge clock);
      #1;
      reset          = rst;
      request_enable = en;
      request_lock   = lk;
      write_full     = full;
      e.grant   = exp_g;
      e.chk_cnt = cc;
      e.cnt0    = cv;
      e.name    = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: one expected entry per stimulus cycle, sampled mid-cycle.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t       e;
         logic       ewe;
         logic [7:0] edata;
         e     = exp_q.pop_front();
         ewe   = |e.grant;
         edata = 8'h00;
         for (int i = 0; i < 4; i++) if (e.grant[i]) edata = 8'(8'hA0 + i);
         checks++;
         if (request_grant !== e.grant || write_enable !== ewe || write_data !== edata) begin
            errors++;
            $display("FAIL %s: got grant=%b we=%b data=%h, expected grant=%b we=%b data=%h",
                     e.name, request_grant, write_enable, write_data, e.grant, ewe, edata);
         end
`ifdef FIFO_WRITE_ARBITER_STATISTICS_EN
         if (e.chk_cnt) begin
            checks++;
            if (grant_count[0] !== e.cnt0) begin
               errors++;
               $display("FAIL %s count0: got %0d, expected %0d", e.name, grant_count[0], e.cnt0);
            end
         end
`endif
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) request_data[i] = 8'(8'hA0 + i);
      reset          = 1'b1;
      request_enable = 4'h0;
      request_lock   = 4'h0;
      write_full     = 1'b0;

      // Reset state, even with every channel requesting
      step(1'b1, 4'hF, 4'h0, 1'b0, 4'b0000, "reset_quiet");

      // Plain round robin across all four
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0001, "rr_all_0");
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0010, "rr_all_1");
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0100, "rr_all_2");
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b1000, "rr_all_3");
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0001, "rr_all_wrap");
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0010, "rr_all_1b");

      // Sparse requesters 1 and 3, wrap from 3 back to 1
      step(1'b1, 4'h0, 4'h0, 1'b0, 4'b0000, "reset_b");
      step(1'b0, 4'b1010, 4'h0, 1'b0, 4'b0010, "sparse_1");
      step(1'b0, 4'b1010, 4'h0, 1'b0, 4'b1000, "sparse_3");
      step(1'b0, 4'b1010, 4'h0, 1'b0, 4'b0010, "sparse_1b");
      step(1'b0, 4'b1010, 4'h0, 1'b0, 4'b1000, "sparse_3b");

      // FIFO full stalls for 5 cycles, then resumes at channel 2
      step(1'b1, 4'h0, 4'h0, 1'b0, 4'b0000, "reset_c");
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0001, "full_pre0");
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0010, "full_pre1");
      for (int i = 0; i < 5; i++) step(1'b0, 4'hF, 4'h0, 1'b1, 4'b0000, $sformatf("full_hold%0d", i));
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0100, "full_resume2");
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b1000, "full_resume3");

      // Lock: stray lock on channel 1 ignored, channel 2 owns 5 cycles, then 0
      step(1'b1, 4'h0, 4'h0, 1'b0, 4'b0000, "reset_d");
      step(1'b0, 4'b0111, 4'b0010, 1'b0, 4'b0001, "lock_pre0");
      step(1'b0, 4'b0111, 4'b0000, 1'b0, 4'b0010, "lock_pre1");
      for (int i = 0; i < 4; i++) step(1'b0, 4'b0111, 4'b0100, 1'b0, 4'b0100, $sformatf("lock_own%0d", i));
      step(1'b0, 4'b0111, 4'b0000, 1'b0, 4'b0100, "lock_release");
      step(1'b0, 4'b0111, 4'b0000, 1'b0, 4'b0001, "lock_after");

      // Reset during ownership by channel 2
      step(1'b1, 4'h0, 4'h0, 1'b0, 4'b0000, "reset_e");
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0001, "rl_pre0");
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0010, "rl_pre1");
      step(1'b0, 4'hF, 4'b0100, 1'b0, 4'b0100, "rl_own");
      step(1'b0, 4'hF, 4'b0100, 1'b0, 4'b0100, "rl_own2");
      step(1'b1, 4'hF, 4'b0100, 1'b0, 4'b0000, "rl_reset");
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0001, "rl_first");
      step(1'b0, 4'hF, 4'h0, 1'b0, 4'b0010, "rl_second");

`ifdef FIFO_WRITE_ARBITER_STATISTICS_EN
      // Saturating 2-bit counter on channel 0
      step(1'b1, 4'h0, 4'h0, 1'b0, 4'b0000, "reset_f");
      step(1'b0, 4'b0001, 4'h0, 1'b0, 4'b0001, "cnt_g1", 1'b1, 2'd0);
      step(1'b0, 4'b0001, 4'h0, 1'b0, 4'b0001, "cnt_g2", 1'b1, 2'd1);
      step(1'b0, 4'b0001, 4'h0, 1'b0, 4'b0001, "cnt_g3", 1'b1, 2'd2);
      step(1'b0, 4'b0001, 4'h0, 1'b0, 4'b0001, "cnt_g4", 1'b1, 2'd3);
      step(1'b0, 4'b0001, 4'h0, 1'b0, 4'b0001, "cnt_g5", 1'b1, 2'd3);
      step(1'b0, 4'b0000, 4'h0, 1'b0, 4'b0000, "cnt_end", 1'b1, 2'd3);
`endif

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
